// File: rtl/adpcm_mul_arbiter.sv
// ---------------------------------------------------------------------------
// adpcm_mul_arbiter
//
// Shares one unsigned 15x11 -> 27-bit multiplier between NUM_REQ requesters.
// A round-robin arbiter picks one requester per cycle. Its operands go into
// stage S1. The combinational product of S1 is captured into stage S2, and
// S2 drives the tagged response bus directly.
//
// Ports
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   req_valid        : per-requester request valid
//   req_a / req_b    : packed operands, requester i at [15*i +: 15] / [11*i +: 11]
//   req_ready        : one-hot (or zero) accept strobe
//   rsp_valid/id/p   : product response, owned by requester rsp_id
//   rsp_ready        : downstream accepts the response
//   op_count         : completed responses, saturating
//   busy             : either pipeline stage holds data
//
// Handshake rule, used on both sides: a transfer happens on a rising edge
// where valid and ready are both high. Valid and its payload stay stable
// until that edge. Ready may depend combinationally on valid (req_ready does),
// but valid never depends on ready.
// ---------------------------------------------------------------------------
module adpcm_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*15-1:0] req_a,
  input  logic [NUM_REQ*11-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [26:0]          rsp_p,
  input  logic                 rsp_ready,
  output logic [CNT_W-1:0]     op_count,
  output logic                 busy
);

  logic [ID_W-1:0] rr_ptr;

  logic            s1_v;
  logic [14:0]     s1_a;
  logic [10:0]     s1_b;
  logic [ID_W-1:0] s1_id;

  logic            s2_v;
  logic [26:0]     s2_p;
  logic [ID_W-1:0] s2_id;

  logic            s1_adv;
  logic            s2_adv;
  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] nxt_ptr;
  logic [14:0]     sel_a;
  logic [10:0]     sel_b;
  logic            accept;
  logic [26:0]     prod;
  int              cand;

  // S2 can take new data when it is empty or its response leaves this edge;
  // S1 can take new data when it is empty or moves into S2 this edge.
  assign s2_adv = !s2_v || rsp_ready;
  assign s1_adv = !s1_v || s2_adv;

  // Search from rr_ptr upward, wrapping at NUM_REQ; first valid wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && cand == i && req_valid[i]) begin
          found = 1'b1;
          win   = ID_W'(i);
        end
      end
    end
  end

  // Gating with ap_rst_n keeps req_ready low while reset is held, even though
  // the empty pipeline would otherwise allow a grant.
  assign accept = found && s1_adv && ap_rst_n;

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    nxt_ptr   = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        sel_a        = req_a[15*i +: 15];
        sel_b        = req_b[11*i +: 11];
        nxt_ptr      = ID_W'((i + 1) % NUM_REQ);
        req_ready[i] = accept;
      end
    end
  end

  // Zero-extend both operands to the full product width so nothing truncates.
  assign prod = {12'd0, s1_a} * {16'd0, s1_b};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr <= '0;
      s1_v   <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_id  <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= nxt_ptr;
      end
      if (s1_adv) begin
        s1_v <= accept;
        if (accept) begin
          s1_a  <= sel_a;
          s1_b  <= sel_b;
          s1_id <= win;
        end
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s2_v  <= 1'b0;
      s2_p  <= '0;
      s2_id <= '0;
    end else if (s2_adv) begin
      s2_v  <= s1_v;
      s2_p  <= prod;
      s2_id <= s1_id;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      op_count <= '0;
    end else if (s2_v && rsp_ready && (op_count != '1)) begin
      op_count <= op_count + 1'b1;
    end
  end

  assign rsp_valid = s2_v;
  assign rsp_id    = s2_id;
  assign rsp_p     = s2_p;
  assign busy      = s1_v || s2_v;

endmodule
